// File: rtl/sprite_renderer_if.sv
// sprite_renderer_if: groups the raster, sprite-control, ROM and compositor signals of the
// sprite renderer.
//   frame_start  - one-cycle pulse at start of vertical blanking
//   de           - raster coordinate valid
//   pix_x/pix_y  - current raster coordinate
//   pos_x/pos_y  - requested sprite top-left corner
//   sprite_en    - requested sprite visibility
//   rom_addr     - registered sprite ROM address
//   rom_data     - sprite ROM data (asynchronous read of rom_addr)
//   out_de       - de aligned with out_color
//   out_hit      - opaque sprite pixel at this position
//   out_color    - sprite colour when out_hit, else 0
// Modport slave is the renderer; master is the raster source, ROM and compositor side.
interface sprite_renderer_if #(
  parameter int unsigned ADDRESS    = 11,
  parameter int unsigned COLOR_BITS = 24,
  parameter int unsigned COORD_BITS = 10
);
  logic                  frame_start;
  logic                  de;
  logic [COORD_BITS-1:0] pix_x;
  logic [COORD_BITS-1:0] pix_y;
  logic [COORD_BITS-1:0] pos_x;
  logic [COORD_BITS-1:0] pos_y;
  logic                  sprite_en;
  logic [ADDRESS-1:0]    rom_addr;
  logic [COLOR_BITS-1:0] rom_data;
  logic                  out_de;
  logic                  out_hit;
  logic [COLOR_BITS-1:0] out_color;

  modport slave (
    input  frame_start, de, pix_x, pix_y, pos_x, pos_y, sprite_en, rom_data,
    output rom_addr, out_de, out_hit, out_color
  );

  modport master (
    output frame_start, de, pix_x, pix_y, pos_x, pos_y, sprite_en, rom_data,
    input  rom_addr, out_de, out_hit, out_color
  );
endinterface

// File: rtl/sprite_renderer.sv
// sprite_renderer: two-stage pixel pipeline that addresses the sprite ROM for the pixel under
// the beam, applies colour-key transparency and delivers hit/colour to the compositor.
// Sprite position and enable are shadowed on frame_start; animation frames advance every
// FRAME_TICKS frame_start pulses.
//   clk    - pixel clock
//   rst_n  - asynchronous active-low reset
//   bus    - sprite_renderer_if slave (raster in, ROM address/data, compositor out)
module sprite_renderer #(
  parameter int unsigned           ADDRESS     = 11,
  parameter int unsigned           COLOR_BITS  = 24,
  parameter int unsigned           COORD_BITS  = 10,
  parameter int unsigned           SPRITE_W    = 32,
  parameter int unsigned           SPRITE_H    = 32,
  parameter int unsigned           FRAMES      = 2,
  parameter int unsigned           FRAME_TICKS = 15,
  parameter logic [COLOR_BITS-1:0] KEY_COLOR   = COLOR_BITS'(24'hFF00FF)
) (
  input  logic             clk,
  input  logic             rst_n,
  sprite_renderer_if.slave bus
);
  localparam int unsigned TickW     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned AnimW     = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned CW        = COORD_BITS + 1;
  localparam int unsigned FrameSize = SPRITE_W * SPRITE_H;

  // Shadowed sprite state and animation counters
  logic [COORD_BITS-1:0] r_sx;
  logic [COORD_BITS-1:0] r_sy;
  logic                  r_sen;
  logic [TickW-1:0]      r_tick;
  logic [AnimW-1:0]      r_anim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_sen  <= 1'b0;
      r_tick <= '0;
      r_anim <= '0;
    end else if (bus.frame_start) begin
      r_sx  <= bus.pos_x;
      r_sy  <= bus.pos_y;
      r_sen <= bus.sprite_en;
      if (r_tick == TickW'(FRAME_TICKS - 1)) begin
        r_tick <= '0;
        if (r_anim == AnimW'(FRAMES - 1)) begin
          r_anim <= '0;
        end else begin
          r_anim <= r_anim + AnimW'(1);
        end
      end else begin
        r_tick <= r_tick + TickW'(1);
      end
    end
  end

  // Stage 1: hit test one bit wider than the coordinates so right/bottom overhang clips
  logic [CW-1:0]         w_px;
  logic [CW-1:0]         w_py;
  logic [CW-1:0]         w_sx;
  logic [CW-1:0]         w_sy;
  logic [CW-1:0]         w_sx_end;
  logic [CW-1:0]         w_sy_end;
  logic                  w_inside;
  logic [COORD_BITS-1:0] w_dx;
  logic [COORD_BITS-1:0] w_dy;
  logic [31:0]           w_addr_full;

  assign w_px     = {1'b0, bus.pix_x};
  assign w_py     = {1'b0, bus.pix_y};
  assign w_sx     = {1'b0, r_sx};
  assign w_sy     = {1'b0, r_sy};
  assign w_sx_end = w_sx + CW'(SPRITE_W);
  assign w_sy_end = w_sy + CW'(SPRITE_H);
  assign w_inside = bus.de & r_sen & (w_px >= w_sx) & (w_px < w_sx_end)
                  & (w_py >= w_sy) & (w_py < w_sy_end);
  assign w_dx     = bus.pix_x - r_sx;
  assign w_dy     = bus.pix_y - r_sy;
  assign w_addr_full = 32'(r_anim) * 32'(FrameSize) + 32'(w_dy) * 32'(SPRITE_W) + 32'(w_dx);

  logic [ADDRESS-1:0] r_rom_addr;
  logic               r_inside;
  logic               r_de;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_inside   <= 1'b0;
      r_de       <= 1'b0;
    end else begin
      r_rom_addr <= w_inside ? w_addr_full[ADDRESS-1:0] : '0;
      r_inside   <= w_inside;
      r_de       <= bus.de;
    end
  end

  // Stage 2: colour-key transparency on the ROM word addressed in stage 1
  logic                  w_hit;
  logic                  r_out_de;
  logic                  r_out_hit;
  logic [COLOR_BITS-1:0] r_out_color;

  assign w_hit = r_inside & (bus.rom_data != KEY_COLOR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_de    <= 1'b0;
      r_out_hit   <= 1'b0;
      r_out_color <= '0;
    end else begin
      r_out_de    <= r_de;
      r_out_hit   <= w_hit;
      r_out_color <= w_hit ? bus.rom_data : '0;
    end
  end

  assign bus.rom_addr  = r_rom_addr;
  assign bus.out_de    = r_out_de;
  assign bus.out_hit   = r_out_hit;
  assign bus.out_color = r_out_color;
endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: drives sprite_renderer with directed and random raster traffic and checks
// every cycle against a behavioural model of the rendering rules.
`timescale 1ns/1ps
module tb_sprite_renderer;
  localparam int unsigned ADDRESS     = 11;
  localparam int unsigned COLOR_BITS  = 24;
  localparam int unsigned COORD_BITS  = 10;
  localparam int          SW          = 32;
  localparam int          SH          = 32;
  localparam int          NFRAMES     = 2;
  localparam int          TICKS       = 15;
  localparam logic [23:0] KEY         = 24'hFF00FF;
  localparam logic [23:0] BASE        = 24'h123456;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sprite_renderer_if #(
    .ADDRESS    (ADDRESS),
    .COLOR_BITS (COLOR_BITS),
    .COORD_BITS (COORD_BITS)
  ) bus ();

  sprite_renderer #(
    .ADDRESS     (ADDRESS),
    .COLOR_BITS  (COLOR_BITS),
    .COORD_BITS  (COORD_BITS),
    .SPRITE_W    (SW),
    .SPRITE_H    (SH),
    .FRAMES      (NFRAMES),
    .FRAME_TICKS (TICKS),
    .KEY_COLOR   (KEY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [23:0] rom [0:2047];
  assign bus.rom_data = rom[bus.rom_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: shadow state, frame count, and the two pixels in flight
  int m_sx, m_sy, m_fcount;
  bit m_en;
  int p_addr, p_color;
  bit p_in, p_de;
  int px, py, e_addr, e_color, anim;
  bit e_in, e_hit, e_de;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sx = 0; m_sy = 0; m_fcount = 0; m_en = 0;
      p_addr = 0; p_in = 0; p_de = 0;
    end else begin
      px   = int'(bus.pix_x);
      py   = int'(bus.pix_y);
      anim = (m_fcount / TICKS) % NFRAMES;
      e_in = bus.de && m_en && px >= m_sx && px < m_sx + SW && py >= m_sy && py < m_sy + SH;
      e_addr  = e_in ? ((anim * SW * SH + (py - m_sy) * SW + (px - m_sx)) % (1 << ADDRESS)) : 0;
      p_color = int'(rom[p_addr]);
      e_hit   = p_in && (rom[p_addr] != KEY);
      e_color = e_hit ? p_color : 0;
      e_de    = p_de;
      p_in    = e_in;
      p_addr  = e_addr;
      p_de    = bus.de;
      if (bus.frame_start) begin
        m_sx = int'(bus.pos_x);
        m_sy = int'(bus.pos_y);
        m_en = bus.sprite_en;
        m_fcount++;
      end
      #1;
      chk("m_rom_addr", 32'(bus.rom_addr), 32'(e_addr));
      chk("m_out_de", 32'(bus.out_de), 32'(e_de));
      chk("m_out_hit", 32'(bus.out_hit), 32'(e_hit));
      chk("m_out_color", 32'(bus.out_color), 32'(e_color));
    end
  end

  task automatic pulse(input int x, input int y, input bit en);
    @(negedge clk);
    bus.pos_x = COORD_BITS'(x);
    bus.pos_y = COORD_BITS'(y);
    bus.sprite_en = en;
    bus.frame_start = 1'b1;
    bus.de = 1'b0;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic probe(input string nm, input int x, input int y, input int ea, input bit eh,
                       input logic [23:0] ec);
    @(negedge clk);
    bus.pix_x = COORD_BITS'(x);
    bus.pix_y = COORD_BITS'(y);
    bus.de = 1'b1;
    @(posedge clk); #2;
    chk({nm, "_addr"}, 32'(bus.rom_addr), 32'(ea));
    @(negedge clk);
    bus.de = 1'b0;
    @(posedge clk); #2;
    chk({nm, "_hit"}, 32'(bus.out_hit), 32'(eh));
    chk({nm, "_color"}, 32'(bus.out_color), 32'(ec));
    chk({nm, "_de"}, 32'(bus.out_de), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_start = 0; bus.de = 0; bus.pix_x = 0; bus.pix_y = 0;
    bus.pos_x = 0; bus.pos_y = 0; bus.sprite_en = 0;
    for (int j = 0; j < 1024; j++) rom[j] = BASE;
    for (int j = 1024; j < 2048; j++) rom[j] = 24'h0A0000 | 24'(j - 1024);
    rom[5] = KEY;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_out_de", 32'(bus.out_de), 32'd0);
    chk("rst_out_hit", 32'(bus.out_hit), 32'd0);
    chk("rst_out_color", 32'(bus.out_color), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    pulse(100, 50, 1'b1);
    probe("p100_50", 100, 50, 0, 1'b1, BASE);
    probe("p131_81", 131, 81, 1023, 1'b1, BASE);
    probe("p132_50", 132, 50, 0, 1'b0, 24'h0);
    probe("p99_50", 99, 50, 0, 1'b0, 24'h0);
    probe("key105", 105, 50, 5, 1'b0, 24'h0);

    // Position request without frame_start must not move the sprite
    @(negedge clk) bus.pos_x = 10'd200;
    probe("nomove", 100, 50, 0, 1'b1, BASE);
    pulse(200, 50, 1'b1);
    probe("moved_old", 100, 50, 0, 1'b0, 24'h0);
    probe("moved_new", 200, 50, 0, 1'b1, BASE);

    // Asynchronous reset while the sprite is being drawn
    pulse(100, 50, 1'b1);
    @(negedge clk);
    bus.pix_x = 10'd100; bus.pix_y = 10'd50; bus.de = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    chk("pre_rst_hit", 32'(bus.out_hit), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_hit", 32'(bus.out_hit), 32'd0);
    chk("async_color", 32'(bus.out_color), 32'd0);
    chk("async_addr", 32'(bus.rom_addr), 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    chk("post_rst_hit", 32'(bus.out_hit), 32'd0);
    @(negedge clk) bus.de = 1'b0;

    // Animation: 15 pulses per step, two frames
    repeat (15) pulse(100, 50, 1'b1);
    probe("anim1", 100, 50, 1024, 1'b1, 24'h0A0000);
    repeat (15) pulse(100, 50, 1'b1);
    probe("anim0", 100, 50, 0, 1'b1, BASE);

    // Right-edge overhang clips instead of wrapping
    pulse(1010, 50, 1'b1);
    probe("edge1023", 1023, 50, 13, 1'b1, BASE);
    probe("edge0", 0, 50, 0, 1'b0, 24'h0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        @(negedge clk);
        bus.de = 1'b0; bus.frame_start = 1'b0;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 2048; j++)
          rom[j] = ($urandom_range(0, 7) == 0) ? KEY : 24'($urandom);
      end
      @(negedge clk);
      bus.frame_start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 30) == 0) begin
        bus.pos_x = ($urandom_range(0, 3) == 0) ? COORD_BITS'($urandom_range(990, 1023))
                                                : COORD_BITS'($urandom);
        bus.pos_y = ($urandom_range(0, 3) == 0) ? COORD_BITS'($urandom_range(990, 1023))
                                                : COORD_BITS'($urandom);
      end
      bus.sprite_en = ($urandom_range(0, 5) != 0);
      bus.de = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        bus.pix_x = COORD_BITS'(int'(bus.pos_x) + int'($urandom_range(0, 40)) - 4);
        bus.pix_y = COORD_BITS'(int'(bus.pos_y) + int'($urandom_range(0, 40)) - 4);
      end else begin
        bus.pix_x = COORD_BITS'($urandom);
        bus.pix_y = COORD_BITS'($urandom);
      end
    end
    @(negedge clk);
    bus.de = 1'b0; bus.frame_start = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_renderer.md
Name: sprite_renderer

Overview:
Pixel-pipeline stage that drives the player sprite ROM and consumes its colour output. It receives the current raster coordinate from the video timing block and generates the ROM address for the sprite pixel under the beam. It applies colour-key transparency to the ROM data and delivers a hit flag plus colour to the downstream compositor. It also latches the sprite position once per video frame and steps through the animation frames.

Parameters:
ADDRESS, 11, sprite ROM address width
COLOR_BITS, 24, sprite ROM data / pixel colour width
COORD_BITS, 10, raster and position coordinate width
SPRITE_W, 32, sprite width in pixels
SPRITE_H, 32, sprite height in pixels
FRAMES, 2, animation frames stored back-to-back in ROM; FRAMES*SPRITE_W*SPRITE_H <= 2**ADDRESS
FRAME_TICKS, 15, video frames per animation step (>=1)
KEY_COLOR, 24'hFF00FF, transparent colour (low COLOR_BITS bits used)

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
frame_start  input  1  one-cycle pulse at start of vertical blanking
de  input  1  raster coordinate valid (active video)
pix_x  input  COORD_BITS  current raster column
pix_y  input  COORD_BITS  current raster row
pos_x  input  COORD_BITS  requested sprite left edge
pos_y  input  COORD_BITS  requested sprite top edge
sprite_en  input  1  requested sprite visibility
rom_addr  output  ADDRESS  address to sprite ROM (registered)
rom_data  input  COLOR_BITS  sprite ROM data, asynchronous read of rom_addr
out_de  output  1  de delayed to align with out_color
out_hit  output  1  opaque sprite pixel at this position
out_color  output  COLOR_BITS  sprite colour when out_hit, else 0

Behaviour:
- Reset (async assert, sync release): rom_addr=0, out_de=0, out_hit=0, out_color=0; shadow pos_x/pos_y=0, shadow enable=0, tick counter=0, anim index=0.
- Shadow registers: on frame_start, capture pos_x, pos_y, sprite_en. Only shadow values are used for rendering, so there is no mid-frame tearing. A pixel presented in the same cycle as frame_start uses the old shadow values.
- Animation: on each frame_start, tick increments. When tick==FRAME_TICKS-1, tick wraps to 0 and anim advances. anim wraps from FRAMES-1 to 0. FRAME_TICKS=1 gives one step per frame. The anim value updated by frame_start applies from the next cycle.
- Stage 1 (edge after inputs): inside = de & shadow_en & sx<=pix_x<sx+SPRITE_W & sy<=pix_y<sy+SPRITE_H.
  - Comparisons use COORD_BITS+1 width, so sprites that overhang the right or bottom edge clip rather than wrap.
  - If inside: rom_addr = anim*SPRITE_W*SPRITE_H + (pix_y-sy)*SPRITE_W + (pix_x-sx), truncated to ADDRESS. Otherwise rom_addr=0.
  - Register inside_q and de_q.
- Stage 2 (next edge): sample rom_data. out_de=de_q. out_hit = inside_q & (rom_data != KEY_COLOR). out_color = out_hit ? rom_data : 0.
- Latency: exactly 2 clk from pix_x/pix_y/de to out_*. The block accepts one pixel per cycle with no stalls.
- de low: inside is 0, so out_hit=0 two cycles later. The ROM address is still forced to 0.
- Reset mid-frame: outputs clear immediately. Rendering stays disabled until the next frame_start loads a shadow enable of 1.
- Position changes between frame_start pulses are ignored.

Test Plan:
- Reset then frame_start with pos=(100,50), en=1, ROM frame0 all 24'h123456; raster pixel (100,50) -> rom_addr=0 next cycle; out_hit=1, out_color=24'h123456 two cycles after input.
- Same setup, pixel (131,81) -> rom_addr=1023; pixel (132,50) and (99,50) -> out_hit=0, out_color=0.
- ROM word 5 = KEY_COLOR, pixel (105,50) -> rom_addr=5, out_hit=0, out_color=0, out_de=1.
- Change pos_x to 200 mid-frame without frame_start -> pixel (100,50) still hits. After the next frame_start, (100,50) misses and (200,50) hits.
- FRAME_TICKS=15: issue 15 frame_start pulses -> anim=1, and pixel (100,50) gives rom_addr=1024. After 30 pulses anim=0 and rom_addr=0.
- Sprite at pos_x=1010 (COORD_BITS=10): pixel (1023,y) hits with column offset 13. Pixel (0,y) misses, with no wrap.
- Assert rst_n low mid-line with out_hit=1 -> out_hit, out_color and rom_addr go to 0 without a clock edge. With frame_start absent, pixels inside the old rectangle do not hit.
